joy_db9md_multi: RTL and testbench

- Parametrised successor to the two-player DB9 Mega Drive joystick reader used by the SNAC serial port.
- Drives the shared select line (joy_mdsel) and the player split line (joy_split), samples the 6 active-low DB9 inputs, and decodes 3-button and 6-button pads for 1 or 2 players.
- Classifies each pad as none/2-button, MD 3-button or MD 6-button, and publishes atomically updated active-high button vectors with a frame-valid strobe.
- Sits in the emu top between the USER_IN/USER_OUT pins and the joystick muxing logic.

---
 rtl/joy_db9md_pkg.sv | 39 +++
 rtl/joy_db9md_decode.sv | 51 +++++
 rtl/joy_db9md_multi.sv | 134 +++++++++++++
 tb/tb_joy_db9md_multi.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/joy_db9md_pkg.sv
// Shared constants and types for the DB9 Mega Drive pad scanner.
// Button indices follow the joystick vector layout seen by the emu top.
package joy_db9md_pkg;

    localparam int PHASES = 8;

    localparam int BTN_R     = 0;
    localparam int BTN_L     = 1;
    localparam int BTN_D     = 2;
    localparam int BTN_U     = 3;
    localparam int BTN_B     = 4;
    localparam int BTN_C     = 5;
    localparam int BTN_A     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_MODE  = 8;
    localparam int BTN_X     = 9;
    localparam int BTN_Y     = 10;
    localparam int BTN_Z     = 11;

    typedef enum logic [1:0] {
        PAD_NONE = 2'd0,
        PAD_MD3  = 2'd1,
        PAD_MD6  = 2'd2
    } pad_type_e;

    typedef enum logic [1:0] {
        ST_GAP,
        ST_DRIVE,
        ST_SAMPLE,
        ST_PUBLISH
    } scan_state_e;

    function automatic pad_type_e pad_classify(input logic md, input logic six);
        if (md && six) return PAD_MD6;
        if (md) return PAD_MD3;
        return PAD_NONE;
    endfunction

endpackage

// File: rtl/joy_db9md_decode.sv
// Combinational decode of one player's eight select-phase samples.
// Samples arrive already inverted, so 1 means pressed / line low.
module joy_db9md_decode
    import joy_db9md_pkg::*;
#(
    parameter int NBTN = 12
) (
    input  logic [PHASES-1:0][5:0] shadow,
    output logic [NBTN-1:0]        buttons,
    output logic [1:0]             pad_type
);

    logic [5:0] s0;
    logic [5:0] s1;
    logic [5:0] s5;
    logic [5:0] s6;
    logic       md;
    logic       six;
    logic       unused_bits;

    assign s0 = shadow[0];
    assign s1 = shadow[1];
    assign s5 = shadow[5];
    assign s6 = shadow[6];

    // Six-button id only counts on a pad that already proved to be MD.
    assign md  = s1[2] & s1[3];
    assign six = md & (s5[3:0] == 4'hF);

    assign pad_type = pad_classify(md, six);

    always_comb begin
        buttons            = '0;
        buttons[BTN_R]     = s0[3];
        buttons[BTN_L]     = s0[2];
        buttons[BTN_D]     = s0[1];
        buttons[BTN_U]     = s0[0];
        buttons[BTN_B]     = s0[4];
        buttons[BTN_C]     = s0[5];
        buttons[BTN_A]     = md & s1[4];
        buttons[BTN_START] = md & s1[5];
        buttons[BTN_MODE]  = six & s6[3];
        buttons[BTN_X]     = six & s6[2];
        buttons[BTN_Y]     = six & s6[1];
        buttons[BTN_Z]     = six & s6[0];
    end

    assign unused_bits = ^{shadow[7], shadow[4], shadow[3], shadow[2],
                           s1[1:0], s5[5:4], s6[5:4]};

endmodule

// File: rtl/joy_db9md_multi.sv
// Scans 1-2 DB9 Mega Drive pads over a shared select line and
// publishes decoded button vectors atomically once per frame.
module joy_db9md_multi
    import joy_db9md_pkg::*;
#(
    parameter int PLAYERS     = 2,
    parameter int STEP_CYCLES = 480,
    parameter int GAP_STEPS   = 170,
    parameter int NBTN        = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [5:0]              joy_in,
    output logic                    joy_mdsel,
    output logic                    joy_split,
    output logic [PLAYERS*NBTN-1:0] joystick,
    output logic [PLAYERS*2-1:0]    pad_type,
    output logic                    frame_valid
);

    localparam int SW = $clog2(STEP_CYCLES);
    localparam int GW = $clog2(GAP_STEPS + 1);
    localparam logic [SW-1:0] STEP_LAST   = SW'(STEP_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST    = GW'(GAP_STEPS - 1);
    localparam logic          LAST_PLAYER = 1'(PLAYERS - 1);

    logic [5:0]    sync1;
    logic [5:0]    sync2;
    logic [SW-1:0] step_cnt;
    logic          tick;
    logic [GW-1:0] gap_cnt;
    logic [2:0]    phase;
    logic          player;
    logic          last_slot;
    scan_state_e   state;
    scan_state_e   state_d;

    logic [PLAYERS-1:0][PHASES-1:0][5:0] shadow;
    logic [PLAYERS*NBTN-1:0]             dec_btn;
    logic [PLAYERS*2-1:0]                dec_type;

    assign tick      = (step_cnt == STEP_LAST);
    assign last_slot = (phase == 3'd7) && (player == LAST_PLAYER);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 6'h3F;
            sync2    <= 6'h3F;
            step_cnt <= '0;
        end else begin
            sync1    <= joy_in;
            sync2    <= sync1;
            step_cnt <= tick ? '0 : step_cnt + 1'b1;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            ST_GAP:     if (tick && gap_cnt == GAP_LAST) state_d = ST_DRIVE;
            ST_DRIVE:   if (tick) state_d = ST_SAMPLE;
            ST_SAMPLE:  if (tick) state_d = last_slot ? ST_PUBLISH : ST_DRIVE;
            ST_PUBLISH: state_d = ST_GAP;
            default:    state_d = ST_GAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_GAP;
        else       state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gap_cnt     <= '0;
            phase       <= '0;
            player      <= 1'b0;
            joy_mdsel   <= 1'b1;
            joy_split   <= 1'b0;
            shadow      <= '0;
            joystick    <= '0;
            pad_type    <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            unique case (state)
                ST_GAP: begin
                    phase     <= '0;
                    player    <= 1'b0;
                    joy_mdsel <= 1'b1;
                    if (tick)
                        gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + 1'b1;
                end
                ST_DRIVE: begin
                    if (tick) begin
                        joy_mdsel <= ~phase[0];
                        joy_split <= player;
                    end
                end
                ST_SAMPLE: begin
                    if (tick) begin
                        for (int p = 0; p < PLAYERS; p++)
                            if (int'(player) == p) shadow[p][phase] <= ~sync2;
                        if (player != LAST_PLAYER) begin
                            player <= player + 1'b1;
                        end else begin
                            player <= 1'b0;
                            phase  <= phase + 1'b1;
                            // Raise select on the closing tick so the gap starts now.
                            if (phase == 3'd7) joy_mdsel <= 1'b1;
                        end
                    end
                end
                ST_PUBLISH: begin
                    joystick    <= dec_btn;
                    pad_type    <= dec_type;
                    frame_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < PLAYERS; g++) begin : g_dec
        joy_db9md_decode #(
            .NBTN(NBTN)
        ) u_dec (
            .shadow  (shadow[g]),
            .buttons (dec_btn[g*NBTN +: NBTN]),
            .pad_type(dec_type[g*2 +: 2])
        );
    end

endmodule

// File: tb/tb_joy_db9md_multi.sv
// Directed bench: pad BFMs with a select-edge counter drive a 2-player
// and a 1-player scanner; decoded vectors and frame timing are checked.
module tb_joy_db9md_multi;

    localparam int STEP = 4;
    localparam int GAP  = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  joy_in;
    logic        joy_mdsel;
    logic        joy_split;
    logic        frame_valid;
    logic [23:0] joystick;
    logic [3:0]  pad_type;
    logic        joy_mdsel1;
    logic        joy_split1;
    logic        frame_valid1;
    logic [11:0] joystick1;
    logic [1:0]  pad_type1;

    int n_cmp = 0;
    int n_err = 0;

    int          pad_kind [2];
    logic [11:0] pad_btn  [2];

    logic prev_sel   = 1'b1;
    logic prev_split = 1'b0;
    logic split1_hi  = 1'b0;
    int   hi_cnt     = 0;
    int   falls      = 0;
    int   mon_falls  = 0;
    int   mon_tog    = 0;
    int   eff;

    joy_db9md_multi #(
        .PLAYERS(2), .STEP_CYCLES(STEP), .GAP_STEPS(GAP), .NBTN(12)
    ) dut (
        .clk(clk), .reset(reset), .joy_in(joy_in),
        .joy_mdsel(joy_mdsel), .joy_split(joy_split),
        .joystick(joystick), .pad_type(pad_type), .frame_valid(frame_valid)
    );

    joy_db9md_multi #(
        .PLAYERS(1), .STEP_CYCLES(STEP), .GAP_STEPS(GAP), .NBTN(12)
    ) dut1 (
        .clk(clk), .reset(reset), .joy_in(joy_in),
        .joy_mdsel(joy_mdsel1), .joy_split(joy_split1),
        .joystick(joystick1), .pad_type(pad_type1), .frame_valid(frame_valid1)
    );

    always #5 clk = ~clk;

    // kind: 0 none, 1 Atari, 2 MD 3-button, 3 MD 6-button
    function automatic logic [5:0] pad_pins(input int kind, input logic [11:0] b,
                                            input logic sel, input int cnt);
        logic [5:0] p;
        p = '0;
        case (kind)
            1: p = {b[5], b[4], b[0], b[1], b[2], b[3]};
            2, 3: begin
                if (sel) begin
                    if (kind == 3 && cnt == 3) p = {b[5], b[4], b[8], b[9], b[10], b[11]};
                    else                       p = {b[5], b[4], b[0], b[1], b[2], b[3]};
                end else begin
                    if (kind == 3 && cnt == 3) p = {b[7], b[6], 4'hF};
                    else                       p = {b[7], b[6], 2'b11, b[2], b[3]};
                end
            end
            default: p = '0;
        endcase
        return ~p;
    endfunction

    always @(posedge clk) begin
        prev_sel   <= joy_mdsel;
        prev_split <= joy_split;
        if (joy_mdsel) begin
            if (hi_cnt < 32) hi_cnt <= hi_cnt + 1;
            if (hi_cnt >= 31) falls <= 0;
        end else begin
            hi_cnt <= 0;
            if (prev_sel) falls <= falls + 1;
        end
        if (prev_sel && !joy_mdsel) mon_falls <= mon_falls + 1;
        if (prev_split != joy_split) mon_tog <= mon_tog + 1;
        if (joy_split1) split1_hi <= 1'b1;
    end

    always_comb eff = falls + ((prev_sel && !joy_mdsel) ? 1 : 0);

    always_comb
        joy_in = joy_split ? pad_pins(pad_kind[1], pad_btn[1], joy_mdsel, eff)
                           : pad_pins(pad_kind[0], pad_btn[0], joy_mdsel, eff);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_pulse(input bit which, output int n);
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
            seen = which ? frame_valid1 : frame_valid;
        end
        chk(which ? "fv1_seen" : "fv_seen", 32'(seen), 'd1);
    endtask

    task automatic wait_sel(input logic level);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (joy_mdsel !== level && n < 300);
        chk("sel_seen", 32'(joy_mdsel), 32'(level));
    endtask

    initial begin
        int n;
        int f0;
        int t0;

        pad_kind[0] = 3;
        pad_btn[0]  = 12'h881;
        pad_kind[1] = 0;
        pad_btn[1]  = 12'h000;

        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_joystick", 32'(joystick), 'h0);
        chk("rst_pad_type", 32'(pad_type), 'h0);
        chk("rst_fv",       32'(frame_valid), 'h0);
        chk("rst_mdsel",    32'(joy_mdsel), 'h1);
        chk("rst_split",    32'(joy_split), 'h0);
        chk("rst_joy1",     32'(joystick1), 'h0);
        chk("rst_type1",    32'(pad_type1), 'h0);
        chk("rst_mdsel1",   32'(joy_mdsel1), 'h1);
        reset = 1'b0;

        wait_pulse(0, n);
        chk("a_p0_btn",  32'(joystick[11:0]), 'h881);
        chk("a_p0_type", 32'(pad_type[1:0]), 'd2);
        chk("a_p1_btn",  32'(joystick[23:12]), 'h000);
        chk("a_p1_type", 32'(pad_type[3:2]), 'd0);
        @(posedge clk);
        #1;
        chk("fv_width", 32'(frame_valid), 'h0);

        pad_kind[1] = 2;
        pad_btn[1]  = 12'hF48;
        wait_pulse(0, n);
        f0 = mon_falls;
        t0 = mon_tog;
        chk("b_p1_btn",  32'(joystick[23:12]), 'h048);
        chk("b_p1_type", 32'(pad_type[3:2]), 'd1);
        chk("b_p0_btn",  32'(joystick[11:0]), 'h881);
        chk("b_p0_type", 32'(pad_type[1:0]), 'd2);

        wait_pulse(0, n);
        chk("fv_period_160_162", 32'(n >= 160 && n <= 162), 'd1);
        chk("sel_falls",     32'(mon_falls - f0), 'd4);
        chk("split_toggles", 32'(mon_tog - t0), 'd16);

        wait_pulse(1, n);
        wait_pulse(1, n);
        chk("fv1_period_96_98", 32'(n >= 96 && n <= 98), 'd1);
        chk("split1_low", 32'(split1_hi), 'd0);

        wait_pulse(0, n);
        wait_sel(1'b0);
        pad_btn[0] = 12'h282;
        repeat (20) @(posedge clk);
        #1;
        chk("mid_hold_p0", 32'(joystick[11:0]), 'h881);
        chk("mid_hold_p1", 32'(joystick[23:12]), 'h048);
        wait_pulse(0, n);
        chk("mix_p0_btn",  32'(joystick[11:0]), 'h281);
        chk("mix_p0_type", 32'(pad_type[1:0]), 'd2);

        pad_btn[0] = 12'h881;
        wait_sel(1'b0);
        wait_sel(1'b1);
        wait_sel(1'b0);
        wait_sel(1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("r4_joystick", 32'(joystick), 'h0);
        chk("r4_pad_type", 32'(pad_type), 'h0);
        chk("r4_mdsel",    32'(joy_mdsel), 'h1);
        chk("r4_fv",       32'(frame_valid), 'h0);
        reset = 1'b0;
        wait_pulse(0, n);
        chk("r4_first_fv_158_164", 32'(n >= 158 && n <= 164), 'd1);
        chk("r4_p0_btn",  32'(joystick[11:0]), 'h881);
        chk("r4_p0_type", 32'(pad_type[1:0]), 'd2);
        chk("r4_p1_btn",  32'(joystick[23:12]), 'h048);
        chk("r4_p1_type", 32'(pad_type[3:2]), 'd1);

        pad_kind[0] = 1;
        pad_btn[0]  = 12'h032;
        pad_kind[1] = 0;
        pad_btn[1]  = 12'h000;
        wait_pulse(0, n);
        chk("c_p0_btn",  32'(joystick[11:0]), 'h032);
        chk("c_p0_type", 32'(pad_type[1:0]), 'd0);
        chk("c_p1_btn",  32'(joystick[23:12]), 'h000);
        chk("c_p1_type", 32'(pad_type[3:2]), 'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
